// File: rtl/hood_mode_control.sv
// hood_mode_control: range-hood operating-mode state machine.
// Consumes the registered power state and debounced key pulses, and owns
// the timed level-3 window, the delayed exit from level 3 and the
// self-clean cycle. All outputs are registered.
module hood_mode_control #(
  parameter int TICKS_PER_SEC   = 100000000,
  parameter int LEVEL3_SECS     = 60,
  parameter int EXIT_DELAY_SECS = 60,
  parameter int CLEAN_SECS      = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_state,
  input  logic       menu_key,
  input  logic       level1_key,
  input  logic       level2_key,
  input  logic       level3_key,
  input  logic       clean_key,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] remaining_secs,
  output logic       level3_used,
  output logic       clean_done
);

  // Tick counter wide enough to hold TICKS_PER_SEC-1 (27 bits at the default).
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] L3_LOAD    = 8'(LEVEL3_SECS);
  localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_DELAY_SECS);
  localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_SECS);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    STANDBY   = 3'd1,
    MENU      = 3'd2,
    L1        = 3'd3,
    L2        = 3'd4,
    L3        = 3'd5,
    CLEAN     = 3'd6,
    EXIT_WAIT = 3'd7
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick, tick_next;
  logic [7:0]    rem_next;
  logic          used_next;
  logic          done_next;
  logic [1:0]    fan_next;
  logic          wrap;
  logic          expire;

  // Fan speed implied by a mode; keeps fan_level locked to mode.
  function automatic logic [1:0] fan_for(input state_t s);
    case (s)
      L1:        fan_for = 2'd1;
      L2:        fan_for = 2'd2;
      L3:        fan_for = 2'd3;
      EXIT_WAIT: fan_for = 2'd3;
      default:   fan_for = 2'd0;
    endcase
  endfunction

  assign mode = state;

  // Second boundary and last-second detection for the timed states.
  always_comb begin
    wrap   = (tick == TICK_MAX);
    expire = wrap && (remaining_secs <= 8'd1);
  end

  // Next-state, timer and flag computation.
  always_comb begin
    state_next = state;
    tick_next  = tick;
    rem_next   = remaining_secs;
    used_next  = level3_used;
    done_next  = 1'b0;

    if (!power_state) begin
      state_next = OFF;
      tick_next  = '0;
      rem_next   = 8'd0;
      used_next  = 1'b0;
    end else begin
      case (state)
        OFF: begin
          state_next = STANDBY;
        end
        STANDBY: begin
          if (menu_key) state_next = MENU;
          else          state_next = STANDBY;
        end
        MENU: begin
          if (clean_key) begin
            state_next = CLEAN;
            rem_next   = CLEAN_LOAD;
            tick_next  = '0;
          end else if (level3_key && !level3_used) begin
            state_next = L3;
            rem_next   = L3_LOAD;
            tick_next  = '0;
            used_next  = 1'b1;
          end else if (level2_key) begin
            state_next = L2;
          end else if (level1_key) begin
            state_next = L1;
          end else if (menu_key) begin
            state_next = STANDBY;
          end else begin
            state_next = MENU;
          end
        end
        L1: begin
          if (menu_key)        state_next = STANDBY;
          else if (level2_key) state_next = L2;
          else                 state_next = L1;
        end
        L2: begin
          if (menu_key)        state_next = STANDBY;
          else if (level1_key) state_next = L1;
          else                 state_next = L2;
        end
        L3: begin
          // A menu press takes precedence over a coinciding expiry.
          if (menu_key) begin
            state_next = EXIT_WAIT;
            rem_next   = EXIT_LOAD;
            tick_next  = '0;
          end else if (expire) begin
            state_next = L2;
            rem_next   = 8'd0;
            tick_next  = '0;
          end else if (wrap) begin
            rem_next  = remaining_secs - 8'd1;
            tick_next = '0;
          end else begin
            tick_next = tick + TW'(1);
          end
        end
        EXIT_WAIT, CLEAN: begin
          if (expire) begin
            state_next = STANDBY;
            rem_next   = 8'd0;
            tick_next  = '0;
            done_next  = (state == CLEAN);
          end else if (wrap) begin
            rem_next  = remaining_secs - 8'd1;
            tick_next = '0;
          end else begin
            tick_next = tick + TW'(1);
          end
        end
        default: begin
          state_next = OFF;
          tick_next  = '0;
          rem_next   = 8'd0;
          used_next  = 1'b0;
          done_next  = 1'b0;
        end
      endcase
    end
    fan_next = fan_for(state_next);
  end

  // State, timer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= OFF;
      tick           <= '0;
      fan_level      <= 2'd0;
      remaining_secs <= 8'd0;
      level3_used    <= 1'b0;
      clean_done     <= 1'b0;
    end else begin
      state          <= state_next;
      tick           <= tick_next;
      fan_level      <= fan_next;
      remaining_secs <= rem_next;
      level3_used    <= used_next;
      clean_done     <= done_next;
    end
  end

endmodule

// File: doc/hood_mode_control.md
Name: hood_mode_control

Overview:
- Downstream consumer of the gesture power controller.
- Takes the registered power_state plus single-cycle debounced key pulses, and runs the range-hood operating-mode state machine: standby, menu, extraction levels 1/2/3, and self-clean.
- Owns the timed behaviours: the one-shot level-3 "hurricane" window, the delayed exit from level 3, and the self-clean cycle.
- Drives the fan-level output and the seconds-remaining value used by the display stage.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per second; bench overrides with a small value.
- LEVEL3_SECS, 60, duration of level 3 before automatic drop to level 2; range 1..255.
- EXIT_DELAY_SECS, 60, time fan stays at level 3 after menu exit from level 3; range 1..255.
- CLEAN_SECS, 180, self-clean duration; range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- power_state  input  1  1 = appliance on (from gesture power control)
- menu_key  input  1  one-cycle pulse, menu/back
- level1_key  input  1  one-cycle pulse
- level2_key  input  1  one-cycle pulse
- level3_key  input  1  one-cycle pulse
- clean_key  input  1  one-cycle pulse
- mode  output  3  current state encoding: OFF=0, STANDBY=1, MENU=2, L1=3, L2=4, L3=5, CLEAN=6, EXIT_WAIT=7
- fan_level  output  2  L1→1, L2→2, L3/EXIT_WAIT→3, otherwise 0
- remaining_secs  output  8  seconds left in a timed state (L3, EXIT_WAIT, CLEAN); 0 elsewhere
- level3_used  output  1  set on entry to L3; cleared only on power-off or reset
- clean_done  output  1  one-cycle pulse on CLEAN expiry

Behaviour:
- Reset values: mode=OFF, fan_level=0, remaining_secs=0, level3_used=0, clean_done=0, internal tick counter=0.
- All outputs are registered. A key sampled high at edge N is reflected in mode/fan_level after edge N (1-cycle latency). fan_level is always consistent with mode in the same cycle.
- Power gating:
  - power_state=0 at any edge forces mode=OFF and clears remaining_secs, the tick counter and level3_used.
  - This overrides all keys and timers. clean_done is not pulsed when CLEAN is aborted.
  - OFF → STANDBY on the first edge with power_state=1. Keys in that same cycle are ignored.
- STANDBY: menu_key → MENU. Other keys are ignored.
- MENU: priority is clean_key > level3_key > level2_key > level1_key > menu_key.
  - clean_key → CLEAN.
  - level3_key → L3 only if level3_used=0; otherwise ignored and the next lower-priority pending key applies.
  - level2_key → L2.
  - level1_key → L1.
  - menu_key → STANDBY.
- L1: level2_key → L2; menu_key → STANDBY (menu_key wins if both asserted).
- L2: level1_key → L1; menu_key → STANDBY (menu_key wins if both asserted).
- L3:
  - On entry: remaining_secs=LEVEL3_SECS, tick counter=0, level3_used=1.
  - Expiry → L2.
  - menu_key → EXIT_WAIT, loading remaining_secs=EXIT_DELAY_SECS and tick counter=0.
  - Level keys are ignored.
- EXIT_WAIT: fan stays at 3. Expiry → STANDBY. All keys are ignored.
- CLEAN: fan_level=0. Expiry → STANDBY with clean_done=1 for exactly that one cycle. All keys are ignored.
- Timing:
  - In timed states the tick counter counts 0..TICKS_PER_SEC-1 and wraps.
  - On the wrap edge, remaining_secs decrements.
  - If remaining_secs=1 on the wrap edge, the state transitions on that same edge and remaining_secs is loaded for the target state (0 for untimed targets).
  - So a timed state lasts exactly SECS*TICKS_PER_SEC cycles from its entry edge.
- The tick counter must be at least 27 bits wide for the default parameter value. Counter arithmetic is unsigned, with no wrap-around past 0.
- Undefined encodings are unreachable, but a decoded default forces OFF with all outputs cleared.
- Reset asserted mid-operation immediately returns to the reset values listed above.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, LEVEL3_SECS=3, EXIT_DELAY_SECS=2, CLEAN_SECS=5.
- Power-up sequence: reset released, power_state=1, then menu_key, then level2_key → mode 0→1→2→4 on successive edges, fan_level=2; then level1_key → mode=3, fan_level=1.
- Level-3 expiry: from MENU pulse level3_key → mode=5, fan=3, remaining_secs=3, level3_used=1; after exactly 12 cycles mode=4, fan=2, remaining_secs=0.
- Level-3 is one-shot: return to MENU, pulse level3_key → mode stays 2. Then toggle power_state 1→0→1 → level3_used=0, and level3_key from MENU is accepted again.
- Delayed exit: in L3 after 5 cycles pulse menu_key → mode=7, fan=3, remaining_secs=2; 8 cycles later mode=1, fan=0.
- Self-clean: from MENU pulse clean_key with level3_key in the same cycle → mode=6 (clean wins), fan=0; after 20 cycles mode=1 and clean_done high for exactly 1 cycle. Repeat, dropping power_state at cycle 10 → mode=0 next edge and clean_done never asserts.
- Reset mid-L3 (remaining_secs=2) → all outputs 0 immediately, asynchronously, before the next clk edge.
